// File: rtl/nlms_weight_update.sv
// rtl/nlms_weight_update.sv - NLMS weight update, one tap per clock, atomic commit of all weights
//
// Purpose: applies w[k] += sat((err * x[k]) >>> MU_SHIFT) to NTAPS weights.
//   The run starts from a snapshot of err and x_bus and walks the taps in order.
//   Results build up in a working bank. The whole bank is copied to w_bus in
//   one cycle, so the filter never sees a partly updated weight set.
// Ports:
//   clk    rising-edge clock
//   rstn   synchronous active-low reset
//   start  request one update run (accepted only in IDLE, and not with clr)
//   clr    force working and committed weights to W_INIT, abort any run
//   err    signed error sample
//   x_bus  NTAPS packed signed taps, slice k = x[k]
//   busy   high from start acceptance until commit
//   done   one-cycle pulse after commit; w_bus holds the new weights
//   sat    sticky per run: some weight clamped during this run
//   w_bus  NTAPS packed committed weights, slice k = w[k]
module nlms_weight_update #(
  parameter int NTAPS    = 32,
  parameter int XW       = 14,
  parameter int WW       = 32,
  parameter int MU_SHIFT = 8,
  parameter logic signed [WW-1:0] W_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  clr,
  input  logic signed [XW-1:0]  err,
  input  logic [NTAPS*XW-1:0]   x_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  sat,
  output logic [NTAPS*WW-1:0]   w_bus
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  localparam logic [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]        r_idx;
  logic                 r_done;
  logic                 r_sat;
  logic signed [XW-1:0] r_err;
  logic signed [XW-1:0] r_x    [NTAPS];
  logic [WW-1:0]        r_work [NTAPS];
  logic [WW-1:0]        r_wout [NTAPS];

  logic                   w_accept;
  logic                   w_step;
  logic                   w_commit;
  logic signed [XW-1:0]   w_xsel;
  logic [WW-1:0]          w_cur;
  logic signed [2*XW-1:0] w_prod;
  logic signed [2*XW-1:0] w_prod_sh;
  logic [WW:0]            w_p;
  logic [WW:0]            w_sum;
  logic                   w_hi;
  logic                   w_lo;
  logic [WW-1:0]          w_new;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; clr overrides everything, including a same-cycle start
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_UPDATE;
        S_UPDATE: if (r_idx == LAST_IDX) w_next = S_COMMIT;
        S_COMMIT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Output / strobe logic
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start && !clr;
      end
      S_UPDATE: begin
        w_step = !clr;
        busy   = 1'b1;
      end
      S_COMMIT: begin
        w_commit = !clr;
        busy     = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Tap datapath: full-width product, arithmetic shift, one guard bit for the sum
  assign w_xsel    = r_x[r_idx];
  assign w_cur     = r_work[r_idx];
  assign w_prod    = (2*XW)'(r_err) * (2*XW)'(w_xsel);
  assign w_prod_sh = w_prod >>> MU_SHIFT;
  assign w_p       = {{(WW+1-2*XW){w_prod_sh[2*XW-1]}}, w_prod_sh};
  assign w_sum     = {w_cur[WW-1], w_cur} + w_p;
  // Guard bit and top result bit disagree exactly when the sum left the WW-bit range
  assign w_hi      = !w_sum[WW] &&  w_sum[WW-1];
  assign w_lo      =  w_sum[WW] && !w_sum[WW-1];
  assign w_new     = w_hi ? W_MAX : (w_lo ? W_MIN : w_sum[WW-1:0]);

  // Input snapshot, taken only when a run is accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= '0;
      for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      r_err <= err;
      for (int k = 0; k < NTAPS; k++) r_x[k] <= x_bus[k*XW +: XW];
    end
  end

  // Working bank, committed bank and run status
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_idx  <= '0;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_work[k] <= W_INIT;
        r_wout[k] <= W_INIT;
      end
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_idx <= '0;
        r_sat <= 1'b0;
      end
      if (w_step) begin
        r_work[r_idx] <= w_new;
        r_idx         <= r_idx + 1'b1;
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
      if (w_commit) begin
        r_idx <= '0;
        for (int k = 0; k < NTAPS; k++) r_wout[k] <= r_work[k];
      end
    end
  end

  assign done = r_done;
  assign sat  = r_sat;

  for (genvar g = 0; g < NTAPS; g++) begin : g_wbus
    assign w_bus[g*WW +: WW] = r_wout[g];
  end

endmodule

// File: tb/tb_nlms_weight_update.sv
// tb/tb_nlms_weight_update.sv - directed self-checking bench for nlms_weight_update
module tb_nlms_weight_update;

  localparam int NTAPS = 32;
  localparam int XW    = 14;
  localparam int WW    = 32;
  localparam logic [31:0] SAT_INIT = 32'h7FFFFFF0;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  start;
  logic                  start2;
  logic                  clr;
  logic signed [XW-1:0]  err;
  logic [NTAPS*XW-1:0]   x_bus;
  logic                  busy, done, sat;
  logic [NTAPS*WW-1:0]   w_bus;
  logic                  busy2, done2, sat2;
  logic [NTAPS*WW-1:0]   w_bus2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nlms_weight_update dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .clr   (clr),
    .err   (err),
    .x_bus (x_bus),
    .busy  (busy),
    .done  (done),
    .sat   (sat),
    .w_bus (w_bus)
  );

  nlms_weight_update #(.W_INIT(SAT_INIT)) dut_sat (
    .clk   (clk),
    .rstn  (rstn),
    .start (start2),
    .clr   (clr),
    .err   (err),
    .x_bus (x_bus),
    .busy  (busy2),
    .done  (done2),
    .sat   (sat2),
    .w_bus (w_bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wk(input int k);
    return w_bus[k*WW +: WW];
  endfunction

  function automatic logic [31:0] wk2(input int k);
    return w_bus2[k*WW +: WW];
  endfunction

  task automatic chk_all(input string tag, input logic [31:0] exp);
    for (int k = 0; k < NTAPS; k++) chk($sformatf("%s[%0d]", tag, k), wk(k), exp);
  endtask

  task automatic set_x_all(input int v);
    for (int k = 0; k < NTAPS; k++) x_bus[k*XW +: XW] = XW'(v);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Start a run on the main DUT and watch 45 edges after the start edge.
  // restart_at / abort_at: relative edge numbers at which start / clr are driven (0 = never).
  task automatic run_main(input int restart_at, input int abort_at,
                          output int done_at, output int ndone, output int nbusy,
                          output logic busy_after_clr);
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    done_at = -1;
    ndone = 0;
    busy_after_clr = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      if (c == restart_at) start = 1'b1;
      if (c == abort_at)   clr   = 1'b1;
      tick();
      start = 1'b0;
      clr   = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == abort_at) busy_after_clr = busy;
    end
  endtask

  initial begin
    int done_at, ndone, nbusy;
    logic bac;

    rstn = 1'b0; start = 1'b0; start2 = 1'b0; clr = 1'b0;
    err = '0; x_bus = '0;

    // 1 reset
    tick(); tick();
    rstn = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk_all("rst_w", 32'd0);
    chk("rst_w2_0", wk2(0), SAT_INIT);
    chk("rst_w2_31", wk2(31), SAT_INIT);

    // 2 single run: 256*1 >>> 8 = 1
    err = 14'sd256;
    set_x_all(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy_s", 32'(busy), 32'd1);
    chk("run_w_hold", wk(0), 32'd0);
    err = 14'sd0;
    set_x_all(0);
    nbusy = 1; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (busy) nbusy++;
      if (c == 32) chk("run_w_pre_commit", wk(7), 32'd0);
      if (done && done_at < 0) done_at = c;
    end
    chk("run_done_at", 32'(done_at), 32'd33);
    chk("run_busy_cnt", 32'(nbusy), 32'd33);
    chk("run_done_drop", 32'(done), 32'd0);
    chk("run_sat", 32'(sat), 32'd0);
    chk_all("run_w", 32'd1);

    // clr returns weights to W_INIT
    pulse_clr();
    chk_all("clr_w", 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);

    // 3 signed: -512*3>>>8 = -6, -512*-2>>>8 = 4
    err = -14'sd512;
    set_x_all(0);
    x_bus[0*XW +: XW]  = 14'd3;
    x_bus[31*XW +: XW] = XW'(-2);
    run_main(0, 0, done_at, ndone, nbusy, bac);
    chk("sgn_done_at", 32'(done_at), 32'd33);
    chk("sgn_w0", wk(0), 32'hFFFFFFFA);
    chk("sgn_w31", wk(31), 32'd4);
    chk("sgn_w5", wk(5), 32'd0);
    chk("sgn_w30", wk(30), 32'd0);
    chk("sgn_sat", 32'(sat), 32'd0);

    // 4 saturation on the second instance: 8191*8191>>>8 = 262079 overflows 0x7FFFFFF0
    pulse_clr();
    err = 14'sd8191;
    set_x_all(0);
    x_bus[5*XW +: XW] = 14'd8191;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done2 && done_at < 0) done_at = c;
    end
    chk("sat_done_at", 32'(done_at), 32'd33);
    chk("sat_w5", wk2(5), 32'h7FFFFFFF);
    chk("sat_w4", wk2(4), SAT_INIT);
    chk("sat_w6", wk2(6), SAT_INIT);
    chk("sat_flag", 32'(sat2), 32'd1);
    chk("sat_main_idle", wk(5), 32'd0);

    // err=0 run: sat clears on acceptance, weights unchanged, done still pulses
    err = 14'sd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("z_sat_clear", 32'(sat2), 32'd0);
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done2) ndone++;
    end
    chk("z_ndone", 32'(ndone), 32'd1);
    chk("z_w5", wk2(5), 32'h7FFFFFFF);
    chk("z_w0", wk2(0), SAT_INIT);

    // 5 start while busy is ignored
    pulse_clr();
    err = 14'sd256;
    set_x_all(1);
    run_main(10, 0, done_at, ndone, nbusy, bac);
    chk("rb_ndone", 32'(ndone), 32'd1);
    chk("rb_done_at", 32'(done_at), 32'd33);
    chk("rb_busy_cnt", 32'(nbusy), 32'd33);
    chk("rb_w0", wk(0), 32'd1);
    chk("rb_w31", wk(31), 32'd1);

    // 6 abort with clr mid-run, then a fresh run
    run_main(0, 20, done_at, ndone, nbusy, bac);
    chk("ab_ndone", 32'(ndone), 32'd0);
    chk("ab_busy", 32'(bac), 32'd0);
    chk_all("ab_w", 32'd0);
    run_main(0, 0, done_at, ndone, nbusy, bac);
    chk("ab2_done_at", 32'(done_at), 32'd33);
    chk_all("ab2_w", 32'd1);

    // start and clr together: clr wins
    start = 1'b1;
    clr = 1'b1;
    tick();
    start = 1'b0;
    clr = 1'b0;
    chk("sc_busy", 32'(busy), 32'd0);
    chk("sc_w0", wk(0), 32'd0);

    // reset mid-run: no done
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("rr_ndone", 32'(ndone), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_w0", wk(0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
